// File: rtl/aligner_sequencer.sv
// aligner_sequencer: sorts an FP operand pair by magnitude and right-aligns the smaller fraction
// a few bits per cycle, collecting guard/round/sticky.
module aligner_sequencer #(
  parameter int SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        operand_sign_a,
  input  logic        operand_sign_b,
  input  logic [7:0]  unbiased_exponent_a,
  input  logic [7:0]  unbiased_exponent_b,
  input  logic [23:0] operand_fraction_a,
  input  logic [23:0] operand_fraction_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_exchanged,
  output logic        out_sign_a,
  output logic [7:0]  out_exponent_a,
  output logic [23:0] out_fraction_a,
  output logic        out_sign_b,
  output logic [23:0] out_fraction_b,
  output logic        out_guard,
  output logic        out_round,
  output logic        out_sticky
);
  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;
  state_t state, state_d;
  logic        sa, sb;
  logic [7:0]  ea, eb, exp_hi, exp_lo;
  logic [23:0] fa, fb;
  logic [25:0] sr, mask;
  logic        sticky, exch;
  logic [4:0]  rem, n, s;
  logic [8:0]  diff;
  always_comb begin
    exch   = ($signed(eb) > $signed(ea)) | ((eb == ea) & (fb > fa));
    exp_hi = exch ? eb : ea;
    exp_lo = exch ? ea : eb;
    diff   = {exp_hi[7], exp_hi} - {exp_lo[7], exp_lo};
    n      = (diff > 9'd26) ? 5'd26 : diff[4:0];
    s      = (rem < 5'(SHIFT_STEP)) ? rem : 5'(SHIFT_STEP);
    mask   = ~(26'h3ffffff << s);
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (in_valid & in_ready) ? COMPARE : IDLE;
      COMPARE: state_d = (n == 5'd0) ? DONE : SHIFT;
      SHIFT:   state_d = (rem <= 5'(SHIFT_STEP)) ? DONE : SHIFT;
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  assign in_ready       = (state == IDLE) & ~reset & ~flush;
  assign out_valid      = (state == DONE);
  assign out_fraction_b = sr[25:2];
  assign out_guard      = sr[1];
  assign out_round      = sr[0];
  assign out_sticky     = sticky;
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      {sa, sb, ea, eb, fa, fb} <= '0;
      sr             <= '0;
      sticky         <= 1'b0;
      rem            <= '0;
      out_exchanged  <= 1'b0;
      out_sign_a     <= 1'b0;
      out_exponent_a <= '0;
      out_fraction_a <= '0;
      out_sign_b     <= 1'b0;
    end else begin
      state <= state_d;
      if (in_valid && in_ready) begin
        sa <= operand_sign_a;
        sb <= operand_sign_b;
        ea <= unbiased_exponent_a;
        eb <= unbiased_exponent_b;
        fa <= operand_fraction_a;
        fb <= operand_fraction_b;
      end
      // flush aborts the operation but keeps whatever data outputs were last presented
      if (state == COMPARE && !flush) begin
        out_exchanged  <= exch;
        out_sign_a     <= exch ? sb : sa;
        out_exponent_a <= exp_hi;
        out_fraction_a <= exch ? fb : fa;
        out_sign_b     <= exch ? sa : sb;
        sr             <= {exch ? fa : fb, 2'b00};
        sticky         <= 1'b0;
        rem            <= n;
      end
      if (state == SHIFT && !flush) begin
        sticky <= sticky | (|(sr & mask));
        sr     <= sr >> s;
        rem    <= rem - s;
      end
    end
  end
endmodule

// File: tb/tb_aligner_sequencer.sv
// tb_aligner_sequencer: table-driven vectors with a scoreboard queue, plus backpressure, flush,
// reset-in-DONE and a SHIFT_STEP=1 latency sequence.
module tb_aligner_sequencer;
  typedef struct {
    logic        sa;
    logic [7:0]  ea;
    logic [23:0] fa;
    logic        sb;
    logic [7:0]  eb;
    logic [23:0] fb;
    logic [61:0] res;
    int          lat;
  } vec_t;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, in_valid1 = 0, out_ready = 0, out_ready1 = 1;
  logic sign_a = 0, sign_b = 0;
  logic [7:0] exp_a = 0, exp_b = 0;
  logic [23:0] frac_a = 0, frac_b = 0;
  logic in_ready, out_valid, out_exchanged, out_sign_a, out_sign_b, out_guard, out_round, out_sticky;
  logic [7:0] out_exponent_a;
  logic [23:0] out_fraction_a, out_fraction_b;
  logic in_ready1, o1_valid, o1_exch, o1_sa, o1_sb, o1_g, o1_r, o1_s;
  logic [7:0] o1_ea;
  logic [23:0] o1_fa, o1_fb;
  int checks = 0, errors = 0, cyc = 0, acc = 0;
  logic [61:0] exp_q[$];
  int lat_q[$];
  vec_t vecs[8];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  aligner_sequencer #(.SHIFT_STEP(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .operand_sign_a(sign_a), .operand_sign_b(sign_b),
    .unbiased_exponent_a(exp_a), .unbiased_exponent_b(exp_b),
    .operand_fraction_a(frac_a), .operand_fraction_b(frac_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_exchanged(out_exchanged),
    .out_sign_a(out_sign_a), .out_exponent_a(out_exponent_a), .out_fraction_a(out_fraction_a),
    .out_sign_b(out_sign_b), .out_fraction_b(out_fraction_b),
    .out_guard(out_guard), .out_round(out_round), .out_sticky(out_sticky));
  aligner_sequencer #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid1), .in_ready(in_ready1),
    .operand_sign_a(sign_a), .operand_sign_b(sign_b),
    .unbiased_exponent_a(exp_a), .unbiased_exponent_b(exp_b),
    .operand_fraction_a(frac_a), .operand_fraction_b(frac_b),
    .out_valid(o1_valid), .out_ready(out_ready1), .out_exchanged(o1_exch),
    .out_sign_a(o1_sa), .out_exponent_a(o1_ea), .out_fraction_a(o1_fa),
    .out_sign_b(o1_sb), .out_fraction_b(o1_fb),
    .out_guard(o1_g), .out_round(o1_r), .out_sticky(o1_s));
  function automatic vec_t mkv(input logic sa, input logic [7:0] ea, input logic [23:0] fa,
                               input logic sb, input logic [7:0] eb, input logic [23:0] fb,
                               input logic ex, input logic osa, input logic [7:0] oea,
                               input logic [23:0] ofa, input logic osb, input logic [23:0] ofb,
                               input logic g, input logic r, input logic st, input int lat);
    vec_t v;
    v.sa = sa; v.ea = ea; v.fa = fa; v.sb = sb; v.eb = eb; v.fb = fb;
    v.res = {ex, osa, oea, ofa, osb, ofb, g, r, st};
    v.lat = lat;
    return v;
  endfunction
  function automatic logic [61:0] act_out();
    return {out_exchanged, out_sign_a, out_exponent_a, out_fraction_a, out_sign_b,
            out_fraction_b, out_guard, out_round, out_sticky};
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input vec_t v);
    sign_a = v.sa; exp_a = v.ea; frac_a = v.fa;
    sign_b = v.sb; exp_b = v.eb; frac_b = v.fb;
  endtask
  task automatic send(input vec_t v, input bit push);
    drive(v);
    in_valid = 1;
    for (int k = 0; k < 40 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL accept_timeout: in_ready stayed 0");
    end
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
    if (push) begin
      exp_q.push_back(v.res);
      lat_q.push_back(v.lat);
    end
  endtask
  task automatic collect(input int hold);
    logic [61:0] e;
    int el;
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    if (!out_valid) begin
      errors++; checks++;
      $display("FAIL out_timeout: out_valid never rose, expected latency %0d", el);
      return;
    end
    chk("latency", 64'(cyc - acc), 64'(el));
    chk("result", 64'(act_out()), 64'(e));
    for (int i = 0; i < hold; i++) begin
      chk("hold", {in_ready, out_valid, act_out()}, {2'b01, e});
      @(negedge clk);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    @(negedge clk);
    chk("release", {62'd0, in_ready, out_valid}, 64'd2);
  endtask
  initial begin
    bit seen;
    vecs[0] = mkv(0, 8'd3, 24'hC00000, 0, 8'd5, 24'h800000, 1, 0, 8'd5, 24'h800000, 0, 24'h300000, 0, 0, 0, 2);
    vecs[1] = mkv(0, 8'd0, 24'h900000, 1, 8'd0, 24'hA00000, 1, 1, 8'd0, 24'hA00000, 0, 24'h900000, 0, 0, 0, 1);
    vecs[2] = mkv(1, 8'hFE, 24'h800007, 0, 8'd1, 24'h800000, 1, 0, 8'd1, 24'h800000, 1, 24'h100000, 1, 1, 1, 2);
    vecs[3] = mkv(0, 8'd40, 24'h800001, 1, 8'd10, 24'hFFFFFF, 0, 0, 8'd40, 24'h800001, 1, 24'h000000, 0, 0, 1, 8);
    vecs[4] = mkv(0, 8'h80, 24'h800000, 1, 8'h7F, 24'hC00000, 1, 1, 8'h7F, 24'hC00000, 0, 24'h000000, 0, 0, 1, 8);
    vecs[5] = mkv(1, 8'h10, 24'hABCDEF, 0, 8'h10, 24'hABCDEF, 0, 1, 8'h10, 24'hABCDEF, 0, 24'hABCDEF, 0, 0, 0, 1);
    vecs[6] = mkv(0, 8'd5, 24'h800001, 0, 8'd4, 24'hFFFFFF, 0, 0, 8'd5, 24'h800001, 0, 24'h7FFFFF, 1, 0, 0, 2);
    vecs[7] = mkv(1, 8'd0, 24'h80001F, 0, 8'd5, 24'h800000, 1, 0, 8'd5, 24'h800000, 1, 24'h040000, 1, 1, 1, 3);
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, act_out()}, {2'b10, 62'd0});
    for (int i = 0; i < 8; i++) begin
      send(vecs[i], 1);
      collect(0);
    end
    send(vecs[4], 1);
    collect(5);
    send(vecs[5], 1);
    collect(0);
    // flush during the third SHIFT cycle of a saturating operation
    send(vecs[3], 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    @(negedge clk);
    chk("flush_idle", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("flush_no_valid", {63'd0, seen}, 64'd0);
    send(vecs[0], 1);
    collect(0);
    // reset while parked in DONE
    send(vecs[1], 0);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    chk("done_before_reset", {63'd0, out_valid}, 64'd1);
    reset = 1;
    #1;
    chk("ready_low_in_reset", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("reset_in_done", {in_ready, out_valid, act_out()}, {2'b10, 62'd0});
    send(vecs[2], 1);
    collect(0);
    // single-bit stepping: saturation takes 1 + 26 cycles
    drive(vecs[3]);
    in_valid1 = 1;
    for (int k = 0; k < 20 && !in_ready1; k++) @(negedge clk);
    @(posedge clk); #1;
    acc = cyc;
    in_valid1 = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o1_valid) break;
    end
    chk("step1_latency", 64'(cyc - acc), 64'd27);
    chk("step1_result", 64'({o1_exch, o1_sa, o1_ea, o1_fa, o1_sb, o1_fb, o1_g, o1_r, o1_s}), 64'(vecs[3].res));
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
